cnte_mod: RTL



---
 rtl/cnte_mod_if.sv | 26 ++
 rtl/cnte_mod.sv | 60 ++++++
 2 files changed

// File: rtl/cnte_mod_if.sv
// Control and status bundle for the cnte_mod loadable up/down counter.
// The master drives the controls, the counter (slave) returns its registered state.
interface cnte_mod_if #(
   parameter int WIDTH = 3
);
   // There is no valid/ready pair. Every control is sampled on each rising
   // clock edge, and every status output is a flop that changes only on that edge.
   logic             cnten;
   logic             up;
   logic             load;
   logic [WIDTH-1:0] ld_data;
   logic [WIDTH-1:0] limit;
   logic [WIDTH-1:0] count;
   logic             tc;
   logic             zero;

   modport master (
      output cnten, up, load, ld_data, limit,
      input  count, tc, zero
   );

   modport slave (
      input  cnten, up, load, ld_data, limit,
      output count, tc, zero
   );
endinterface

// File: rtl/cnte_mod.sv
// Loadable up/down counter with a programmable terminal value.
// It either wraps or saturates at the end of its range, and it produces registered tc and zero flags.
module cnte_mod #(
   parameter int WIDTH    = 3,
   parameter bit SATURATE = 1'b0
) (
   input  logic        clk,
   input  logic        reset_n,
   cnte_mod_if.slave   bus
);

   logic [WIDTH-1:0] count_q, count_d;
   logic             tc_q, tc_d;
   logic             zero_q, zero_d;

   // Priority is load, then count, then hold.
   // The limit input is used directly each cycle, so a new limit takes effect at once.
   always_comb begin
      count_d = count_q;
      tc_d    = 1'b0;
      if (bus.load) begin
         count_d = bus.ld_data;
      end else if (bus.cnten) begin
         if (bus.up) begin
            if (count_q >= bus.limit) begin
               tc_d    = 1'b1;
               count_d = SATURATE ? bus.limit : '0;
            end else begin
               count_d = count_q + WIDTH'(1);
            end
         end else begin
            if (count_q == '0) begin
               tc_d    = 1'b1;
               count_d = SATURATE ? '0 : bus.limit;
            end else begin
               count_d = count_q - WIDTH'(1);
            end
         end
      end
      // zero is computed from the next count value, so it lines up with count in the same cycle.
      zero_d = (count_d == '0);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
         tc_q    <= 1'b0;
         zero_q  <= 1'b1;
      end else begin
         count_q <= count_d;
         tc_q    <= tc_d;
         zero_q  <= zero_d;
      end
   end

   assign bus.count = count_q;
   assign bus.tc    = tc_q;
   assign bus.zero  = zero_q;

endmodule
